// File: rtl/lbm_macro_readout.sv
// Lattice readout scanner: walks all cells, reduces the nine distributions to rho/mx/my, streams one record per cell.
// Optional barrier masking is compiled in with `define LBM_READOUT_BARRIER_MASK_EN.
module lbm_macro_readout #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 12,
    parameter int WIDTH      = 64,
    parameter int DEPTH      = 4096
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic [ADDR_WIDTH-1:0]   rd_addr,
    input  logic [DATA_WIDTH-1:0]   f0,
    input  logic [DATA_WIDTH-1:0]   fn,
    input  logic [DATA_WIDTH-1:0]   fne,
    input  logic [DATA_WIDTH-1:0]   fe,
    input  logic [DATA_WIDTH-1:0]   fse,
    input  logic [DATA_WIDTH-1:0]   fs,
    input  logic [DATA_WIDTH-1:0]   fsw,
    input  logic [DATA_WIDTH-1:0]   fw,
    input  logic [DATA_WIDTH-1:0]   fnw,
    input  logic                    barrier_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ADDR_WIDTH-1:0]   out_index,
    output logic [ADDR_WIDTH-1:0]   out_x,
    output logic [ADDR_WIDTH-1:0]   out_y,
    output logic [DATA_WIDTH+3:0]   out_rho,
    output logic [DATA_WIDTH+3:0]   out_mx,
    output logic [DATA_WIDTH+3:0]   out_my,
    output logic                    out_barrier
);

    localparam int SW    = DATA_WIDTH + 4;
    localparam int REC_W = 3 * ADDR_WIDTH + 3 * SW + 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_X   = ADDR_WIDTH'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

    state_t                 state_reg, state_next;
    logic [ADDR_WIDTH-1:0]  idx_reg, idx_next;
    logic [ADDR_WIDTH-1:0]  x_reg, x_next;
    logic [ADDR_WIDTH-1:0]  y_reg, y_next;

    // Metadata of the read whose data arrives this cycle.
    logic                   inflight_reg;
    logic [ADDR_WIDTH-1:0]  idx_d_reg, x_d_reg, y_d_reg;

    logic [REC_W-1:0]       fifo_mem [2];
    logic [1:0]             count_reg;
    logic                   wr_ptr_reg, rd_ptr_reg;

    logic                   pop, push, issue;
    logic [2:0]             occ;

    logic [DATA_WIDTH-1:0]  f_in [9];
    logic [SW-1:0]          fx   [9];
    logic [SW-1:0]          rho_sum, mx_sum, my_sum;
    logic [SW-1:0]          rho_val, mx_val, my_val;
    logic                   bar_val;
    logic [REC_W-1:0]       rec_in, head;

    assign f_in[0] = f0;
    assign f_in[1] = fn;
    assign f_in[2] = fne;
    assign f_in[3] = fe;
    assign f_in[4] = fse;
    assign f_in[5] = fs;
    assign f_in[6] = fsw;
    assign f_in[7] = fw;
    assign f_in[8] = fnw;

    generate
        for (genvar gi = 0; gi < 9; gi++) begin : g_sext
            assign fx[gi] = {{4{f_in[gi][DATA_WIDTH-1]}}, f_in[gi]};
        end
    endgenerate

    always_comb begin
        rho_sum = '0;
        for (int i = 0; i < 9; i++) begin
            rho_sum = rho_sum + fx[i];
        end
    end

    // Index map: 0 C, 1 N, 2 NE, 3 E, 4 SE, 5 S, 6 SW, 7 W, 8 NW.
    assign mx_sum = (fx[3] + fx[2] + fx[4]) - (fx[7] + fx[8] + fx[6]);
    assign my_sum = (fx[1] + fx[2] + fx[8]) - (fx[5] + fx[4] + fx[6]);

`ifdef LBM_READOUT_BARRIER_MASK_EN
    assign bar_val = barrier_in;
    assign rho_val = bar_val ? '0 : rho_sum;
    assign mx_val  = bar_val ? '0 : mx_sum;
    assign my_val  = bar_val ? '0 : my_sum;
`else
    logic unused_barrier;
    assign unused_barrier = barrier_in;
    assign bar_val = 1'b0;
    assign rho_val = rho_sum;
    assign mx_val  = mx_sum;
    assign my_val  = my_sum;
`endif

    assign rec_in = {idx_d_reg, x_d_reg, y_d_reg, rho_val, mx_val, my_val, bar_val};

    assign out_valid = (count_reg != 2'd0);
    assign head      = out_valid ? fifo_mem[rd_ptr_reg] : '0;
    assign {out_index, out_x, out_y, out_rho, out_mx, out_my, out_barrier} = head;

    assign pop  = out_valid & out_ready;
    assign push = inflight_reg;
    // Counting the in-flight read as occupied guarantees its FIFO slot.
    assign occ   = {1'b0, count_reg} + {2'b00, inflight_reg};
    assign issue = (state_reg == SCAN) && (occ < (3'd2 + {2'b00, pop}));

    assign busy    = (state_reg != IDLE);
    assign rd_addr = idx_reg;

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        x_next     = x_reg;
        y_next     = y_reg;
        done       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = SCAN;
                    idx_next   = '0;
                    x_next     = '0;
                    y_next     = '0;
                end
            end
            SCAN: begin
                if (issue) begin
                    if (idx_reg == LAST_IDX) begin
                        state_next = DRAIN;
                        idx_next   = '0;
                        x_next     = '0;
                        y_next     = '0;
                    end else begin
                        idx_next = idx_reg + 1'b1;
                        if (x_reg == LAST_X) begin
                            x_next = '0;
                            y_next = y_reg + 1'b1;
                        end else begin
                            x_next = x_reg + 1'b1;
                        end
                    end
                end
            end
            DRAIN: begin
                if (count_reg == 2'd0 && !inflight_reg) begin
                    state_next = IDLE;
                    done       = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            idx_reg      <= '0;
            x_reg        <= '0;
            y_reg        <= '0;
            inflight_reg <= 1'b0;
            idx_d_reg    <= '0;
            x_d_reg      <= '0;
            y_d_reg      <= '0;
        end else begin
            state_reg    <= state_next;
            idx_reg      <= idx_next;
            x_reg        <= x_next;
            y_reg        <= y_next;
            inflight_reg <= issue;
            if (issue) begin
                idx_d_reg <= idx_reg;
                x_d_reg   <= x_reg;
                y_d_reg   <= y_reg;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                fifo_mem[i] <= '0;
            end
            count_reg  <= 2'd0;
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr_reg] <= rec_in;
                wr_ptr_reg           <= ~wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            count_reg <= count_reg + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_lbm_macro_readout.sv
// Randomized bench for lbm_macro_readout on a 4x4 lattice; expected records come from a per-cell arithmetic model.
// Honours LBM_READOUT_BARRIER_MASK_EN the same way the design does.
module tb_lbm_macro_readout;

    localparam int DW = 16;
    localparam int AW = 12;
    localparam int W  = 4;
    localparam int D  = 16;
    localparam int SW = DW + 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic out_ready = 1'b0;

    always #5 clk = ~clk;

    logic [DW-1:0] ram [9][D];
    logic          bar_mem [D];
    logic [DW-1:0] f_q [9];
    logic          bar_q;

    logic          busy, done, out_valid, out_barrier;
    logic [AW-1:0] rd_addr, out_index, out_x, out_y;
    logic [SW-1:0] out_rho, out_mx, out_my;
    logic [3*AW+3*SW:0] cur_rec;

    assign cur_rec = {out_index, out_x, out_y, out_rho, out_mx, out_my, out_barrier};

    // Nine RAMs plus barrier map with one-cycle registered read.
    always @(posedge clk) begin
        for (int k = 0; k < 9; k++) f_q[k] <= ram[k][rd_addr[3:0]];
        bar_q <= bar_mem[rd_addr[3:0]];
    end

    lbm_macro_readout #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .rd_addr(rd_addr),
        .f0(f_q[0]), .fn(f_q[1]), .fne(f_q[2]), .fe(f_q[3]), .fse(f_q[4]),
        .fs(f_q[5]), .fsw(f_q[6]), .fw(f_q[7]), .fnw(f_q[8]), .barrier_in(bar_q),
        .out_valid(out_valid), .out_ready(out_ready), .out_index(out_index),
        .out_x(out_x), .out_y(out_y), .out_rho(out_rho), .out_mx(out_mx),
        .out_my(out_my), .out_barrier(out_barrier)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int sv(input int k, input int i);
        return int'($signed(ram[k][i]));
    endfunction

    function automatic logic [SW-1:0] m_rho(input int i);
        int s = 0;
        for (int k = 0; k < 9; k++) s += sv(k, i);
        return SW'(s);
    endfunction

    function automatic logic [SW-1:0] m_mx(input int i);
        return SW'(sv(3, i) + sv(2, i) + sv(4, i) - sv(7, i) - sv(8, i) - sv(6, i));
    endfunction

    function automatic logic [SW-1:0] m_my(input int i);
        return SW'(sv(1, i) + sv(2, i) + sv(8, i) - sv(5, i) - sv(4, i) - sv(6, i));
    endfunction

    task automatic check_record(input int i, input bit spot);
        logic masked;
        logic [SW-1:0] neg_mx;
        masked = 1'b0;
`ifdef LBM_READOUT_BARRIER_MASK_EN
        masked = bar_mem[i];
`endif
        neg_mx = SW'(-98301);
        $display("record idx=%0d x=%0d y=%0d rho=%0d mx=%0h my=%0h bar=%0d",
                 out_index, out_x, out_y, out_rho, out_mx, out_my, out_barrier);
        chk("index", out_index, i);
        chk("x", out_x, i % W);
        chk("y", out_y, i / W);
        chk("rho", out_rho, masked ? '0 : m_rho(i));
        chk("mx", out_mx, masked ? '0 : m_mx(i));
        chk("my", out_my, masked ? '0 : m_my(i));
        chk("barrier", out_barrier, masked);
        if (spot && i == 6) begin
            chk("cell6_rho", out_rho, 139);
            chk("cell6_mx", out_mx, 70);
            chk("cell6_my", out_my, 5);
        end
        if (spot && i == 7) chk("cell7_rho_max", out_rho, 294903);
        if (spot && i == 8) chk("cell8_mx_neg", out_mx, neg_mx);
        if (spot && i == 3) begin
`ifdef LBM_READOUT_BARRIER_MASK_EN
            chk("cell3_rho_masked", out_rho, 0);
            chk("cell3_bar", out_barrier, 1);
`else
            chk("cell3_rho_raw", out_rho, m_rho(3));
            chk("cell3_bar", out_barrier, 0);
`endif
        end
    endtask

    task automatic fill_ones();
        for (int i = 0; i < D; i++) begin
            for (int k = 0; k < 9; k++) ram[k][i] = 16'd1;
            bar_mem[i] = 1'b0;
        end
    endtask

    task automatic fill_rand();
        for (int i = 0; i < D; i++) begin
            for (int k = 0; k < 9; k++) ram[k][i] = DW'($urandom_range(0, 65535));
            bar_mem[i] = ($urandom_range(0, 3) == 0);
        end
        for (int k = 0; k < 9; k++) begin
            ram[k][3] = DW'(5 + k);
            ram[k][6] = '0;
            ram[k][7] = 16'h7FFF;
            ram[k][8] = '0;
        end
        bar_mem[3] = 1'b1;
        bar_mem[6] = 1'b0;
        bar_mem[7] = 1'b0;
        bar_mem[8] = 1'b0;
        ram[3][6] = 16'd100;
        ram[7][6] = 16'd30;
        ram[1][6] = 16'd7;
        ram[5][6] = 16'd2;
        ram[7][8] = 16'h7FFF;
        ram[8][8] = 16'h7FFF;
        ram[6][8] = 16'h7FFF;
    endtask

    // mode 0: ready high; mode 1: random ready + stray start; mode 2: ready high, reset at record 7.
    task automatic run_scan(input int mode, input bit spot);
        int n;
        int nxt;
        int dc;
        int vc;
        bit pv;
        bit pr;
        logic [3*AW+3*SW:0] prec;
        n = 0; nxt = 0; dc = 0; vc = 0; pv = 0; pr = 0; prec = '0;
        @(posedge clk);
        #1;
        start = 1'b1;
        out_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 1;
        while (n < 300) begin
            @(negedge clk);
            if (n == 1) begin
                chk("rd_addr_first", rd_addr, 0);
                chk("busy_scan", busy, 1);
            end
            if (mode == 0 && n == 2) chk("valid_t2", out_valid, 0);
            if (mode == 0 && n == 3) chk("valid_t3", out_valid, 1);
            if (pv && !pr) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_stable", cur_rec, prec);
            end
            if (out_valid && out_ready) begin
                check_record(nxt, spot);
                nxt++;
            end
            if (mode == 2 && out_valid && out_index == 7) begin
                rst = 1'b1;
                #1;
                chk("rst_valid", out_valid, 0);
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                @(negedge clk);
                rst = 1'b0;
                repeat (30) begin
                    @(negedge clk);
                    dc += int'(done);
                    vc += int'(out_valid);
                end
                chk("no_done_after_rst", dc, 0);
                chk("no_valid_after_rst", vc, 0);
                $display("scan mode=%0d reset after %0d records", mode, nxt);
                return;
            end
            if (done) begin
                chk("done_count", nxt, D);
                if (mode == 0) begin
                    chk("done_cycle", n, D + 3);
                    start = 1'b1;
                end
                @(posedge clk);
                #1;
                start = 1'b0;
                @(negedge clk);
                chk("idle_after_done", busy, 0);
                $display("scan mode=%0d done at cycle %0d records=%0d", mode, n, nxt);
                return;
            end
            pv = out_valid;
            pr = out_ready;
            prec = cur_rec;
            @(posedge clk);
            #1;
            if (mode == 1) begin
                out_ready = 1'($urandom_range(0, 1));
                start = (n == 5);
            end
            n++;
        end
        chk("scan_finished", n < 300, 1);
    endtask

    initial begin
        fill_ones();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_index", {out_index, out_x, out_y}, 0);
        chk("rst_out_data", {out_rho, out_mx, out_my, out_barrier}, 0);
        rst = 1'b0;
        run_scan(0, 1'b0);
        fill_rand();
        run_scan(0, 1'b1);
        run_scan(1, 1'b1);
        run_scan(1, 1'b1);
        run_scan(2, 1'b1);
        run_scan(0, 1'b1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lbm_macro_readout.md
# lbm_macro_readout

Read-side scanner for the LBM solver's nine per-direction distribution RAMs (C0, CN, CNE, CE, CSE, CS, CSW, CW, CNW). On a start pulse it walks every lattice cell in raster order and drives one shared read address to all nine RAMs. For each cell it computes density and x/y momentum, then streams one record per cell over a valid/ready interface to the host/display path. It is the consumer end of the memories the solver writes, and it runs only while the solver is idle.

## Interface
Parameters:
- DATA_WIDTH, 16: width of one distribution value, two's complement.
- ADDR_WIDTH, 12: RAM address width.
- WIDTH, 64: lattice columns.
- DEPTH, 4096: lattice cells (WIDTH × rows), ≤ 2^ADDR_WIDTH.

Ports (clock and reset first):
- clk, in, 1: clock.
- rst, in, 1: reset, asynchronous, active-high.
- start, in, 1: begin a full-lattice scan. Ignored while busy.
- busy, out, 1: scan in progress.
- done, out, 1: one-cycle pulse after the last record is accepted.
- rd_addr, out, ADDR_WIDTH: shared read address to all nine RAMs and the barrier map.
- f0, fn, fne, fe, fse, fs, fsw, fw, fnw, in, DATA_WIDTH each: RAM data_out. Valid one cycle after rd_addr.
- barrier_in, in, 1: barrier bit for the addressed cell, with the same one-cycle latency.
- out_valid, out, 1: record available.
- out_ready, in, 1: consumer accepts the record.
- out_index, out, ADDR_WIDTH: cell index.
- out_x, out, ADDR_WIDTH: column, 0..WIDTH-1.
- out_y, out, ADDR_WIDTH: row.
- out_rho, out, DATA_WIDTH+4: density.
- out_mx, out, DATA_WIDTH+4: x momentum.
- out_my, out, DATA_WIDTH+4: y momentum.
- out_barrier, out, 1: cell is a barrier.

## Operation
- States: IDLE, SCAN, DRAIN.
  - IDLE → SCAN on start. The index, x and y counters are cleared to 0.
  - SCAN → DRAIN after index DEPTH-1 is issued.
  - DRAIN → IDLE when the output FIFO and in-flight slot are empty. done pulses in that same transition cycle.
- busy=1 in SCAN and DRAIN.
- The address counter issues rd_addr=index and increments. x and y are incremental counters with no modulo: x wraps from WIDTH-1 to 0 and y then increments. The x/y/index values are delayed one cycle so they align with RAM data.
- Arithmetic is combinational on returned data, with each operand sign-extended to DATA_WIDTH+4. There is no saturation and wrap is mod 2^(DATA_WIDTH+4).
  - rho = f0+fn+fne+fe+fse+fs+fsw+fw+fnw.
  - mx = (fe+fne+fse) − (fw+fnw+fsw).
  - my = (fn+fne+fnw) − (fs+fse+fsw); north is positive.
- Results enter a 2-entry output FIFO, and the FIFO head drives the out_* ports.
- Issue is allowed when fifo_count + inflight − (out_valid & out_ready) < 2. This keeps throughput at 1 record/cycle under continuous ready and prevents overflow under backpressure.
- Output records stay stable while out_valid=1 and out_ready=0.
- start during busy has no effect. start and done in the same cycle: done completes first, and start is ignored because busy is still 1.
- rst mid-scan: all state clears immediately, the FIFO is flushed, no done is produced, and the FSM returns to IDLE.

## Timing
- Reset values: busy=0, done=0, rd_addr=0, out_valid=0, out_index/out_x/out_y=0, out_rho/out_mx/out_my=0, out_barrier=0.
- start sampled at edge t: rd_addr=0 during cycle t+1. Data returns in t+2 and is written into the FIFO at the end of t+2. out_valid=1 from cycle t+3.
- With out_ready held high, records 0..DEPTH-1 appear on consecutive cycles. The last handshake is in cycle t+DEPTH+2 and done pulses at t+DEPTH+3.
- rd_addr holds its value when issue is blocked. The RAM still re-reads harmlessly, but only the first read is captured.

## Configuration
- LBM_READOUT_BARRIER_MASK_EN defined: barrier_in is captured with the RAM data. Barrier cells output rho=mx=my=0 and out_barrier=1. Non-barrier cells output their computed values with out_barrier=0.
- Not defined: barrier_in is ignored, out_barrier is tied 0, and all cells output raw computed values. The port list is unchanged.

## Test plan
- WIDTH=4, DEPTH=16, every RAM preloaded with 1, ready high → 16 records, rho=9, mx=0, my=0, x/y raster (index 5 → x=1, y=1), done at start+19.
- Cell 6: fe=100, fw=30, fn=7, fs=2, others 0 → rho=139, mx=70, my=5.
- DATA_WIDTH=16, all nine values 0x7FFF → rho=294903 with no overflow. fw=fnw=fsw=0x7FFF and others 0 → mx=−98301.
- out_ready toggled 1,0,0,1 pseudo-randomly → every index 0..15 appears exactly once, in order, with no duplicates or drops, and outputs are stable while stalled.
- MASK_EN defined, barrier at index 3 with f values nonzero → record 3 has rho=mx=my=0 and out_barrier=1. Without the macro → raw values and out_barrier=0.
- rst asserted at record 7, then start again → out_valid drops within the reset and no done is produced. The rescan begins at index 0 and completes normally.
